// File: rtl/game_pkg.sv
// Shared definitions for the game-state controller slice.
package game_pkg;

   // Default width of the score and high-score counters.
   localparam int SCORE_W_DEF = 16;

   // Game state encodings; 2'b11 is unused and recovers to idle.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_OVER = 2'b10
   } state_t;

endpackage

// File: rtl/game_ctrl_btn_sync.sv
// Two-flop synchroniser for asynchronous buttons with an OR-reduced level
// and a rising-edge detector. A button already held when reset releases
// is not reported as a press until it has been seen released.
module btn_sync #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] btn,
   output logic             lvl,
   output logic             rise
);

   logic [WIDTH-1:0] sync_p0;
   logic [WIDTH-1:0] sync_p1;
   logic             vld_p0;
   logic             vld_p1;
   logic             lvl_q;
   logic             armed;

   assign lvl  = |sync_p1;
   assign rise = lvl & ~lvl_q & armed;

   // Synchroniser stages, fill-valid tracking, edge history and arming.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
         vld_p0  <= 1'b0;
         vld_p1  <= 1'b0;
         lvl_q   <= 1'b0;
         armed   <= 1'b0;
      end else begin
         // stage p0: first metastability flop
         sync_p0 <= btn;
         vld_p0  <= 1'b1;
         // stage p1: settled copy, trustworthy once vld_p1 is set
         sync_p1 <= sync_p0;
         vld_p1  <= vld_p0;
         lvl_q   <= lvl;
         // arm only after a genuine released level has come through
         armed   <= armed | (vld_p1 & ~lvl);
      end
   end

endmodule

// File: rtl/game_ctrl.sv
// Central game-state controller: collision latch, score counter,
// high-score tracking and restart hold-off in one clocked FSM.
module game_ctrl
   import game_pkg::*;
#(
   parameter int SCORE_W        = SCORE_W_DEF,
   parameter int HOLDOFF_FRAMES = 60,
   parameter int HOLDOFF_W      = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               video_on,
   input  logic               goose,
   input  logic               bean,
   input  logic               frame_tick,
   input  logic               score_tick,
   input  logic [1:0]         btn,
   output logic [1:0]         state,
   output logic               hit,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] score_hi,
   output logic               new_hi
);

   localparam logic [HOLDOFF_W-1:0] HOLD_MAX = HOLDOFF_W'(HOLDOFF_FRAMES);

   state_t               state_q;
   logic                 hit_q;
   logic                 new_hi_q;
   logic [SCORE_W-1:0]   score_q;
   logic [SCORE_W-1:0]   score_hi_q;
   logic [HOLDOFF_W-1:0] hold_cnt;

   logic press_lvl;
   logic press_edge;
   logic coll;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      if (&v)
         return v;
      else
         return v + 1'b1;
   endfunction

   btn_sync #(
      .WIDTH (2)
   ) u_btn_sync (
      .clk   (clk),
      .reset (reset),
      .btn   (btn),
      .lvl   (press_lvl),
      .rise  (press_edge)
   );

   assign coll = video_on & goose & bean;

   // Game FSM with all outputs held in registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         hit_q      <= 1'b0;
         new_hi_q   <= 1'b0;
         score_q    <= '0;
         score_hi_q <= '0;
         hold_cnt   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (press_edge) begin
                  state_q  <= ST_RUN;
                  score_q  <= '0;
                  new_hi_q <= 1'b0;
               end
            end
            ST_RUN: begin
               // collision takes priority over a coincident score tick
               if (coll) begin
                  state_q  <= ST_OVER;
                  hit_q    <= 1'b1;
                  hold_cnt <= '0;
                  if (score_q > score_hi_q) begin
                     score_hi_q <= score_q;
                     new_hi_q   <= 1'b1;
                  end
               end else if (score_tick) begin
                  score_q <= sat_inc(score_q);
               end
            end
            ST_OVER: begin
               // a press only counts once the full hold-off has elapsed
               if (press_edge && (hold_cnt == HOLD_MAX)) begin
                  state_q  <= ST_RUN;
                  score_q  <= '0;
                  new_hi_q <= 1'b0;
                  hit_q    <= 1'b0;
               end else if (frame_tick && (hold_cnt != HOLD_MAX)) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               hit_q   <= 1'b0;
            end
         endcase
      end
   end

   assign state    = state_q;
   assign hit      = hit_q;
   assign score    = score_q;
   assign score_hi = score_hi_q;
   assign new_hi   = new_hi_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: start, scoring, collision, hold-off,
// high-score rules, saturation and asynchronous reset.
module tb_game_ctrl;

   logic        clk;
   logic        reset;
   logic        video_on, goose, bean, frame_tick, score_tick;
   logic [1:0]  btn;
   logic [1:0]  state;
   logic        hit, new_hi;
   logic [15:0] score, score_hi;

   logic        score_tick4;
   logic [1:0]  btn4;
   logic [1:0]  state4;
   logic        hit4, new_hi4;
   logic [3:0]  score4, score_hi4;

   int n_checks = 0;
   int n_errors = 0;

   game_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .video_on   (video_on),
      .goose      (goose),
      .bean       (bean),
      .frame_tick (frame_tick),
      .score_tick (score_tick),
      .btn        (btn),
      .state      (state),
      .hit        (hit),
      .score      (score),
      .score_hi   (score_hi),
      .new_hi     (new_hi)
   );

   game_ctrl #(.SCORE_W(4)) dut4 (
      .clk        (clk),
      .reset      (reset),
      .video_on   (1'b0),
      .goose      (1'b0),
      .bean       (1'b0),
      .frame_tick (1'b0),
      .score_tick (score_tick4),
      .btn        (btn4),
      .state      (state4),
      .hit        (hit4),
      .score      (score4),
      .score_hi   (score_hi4),
      .new_hi     (new_hi4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_score(input int n);
      for (int i = 0; i < n; i++) begin
         score_tick = 1'b1;
         tick();
         score_tick = 1'b0;
      end
   endtask

   task automatic pulse_frame(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         tick();
         frame_tick = 1'b0;
         tick();
      end
   endtask

   task automatic collide();
      video_on = 1'b1; goose = 1'b1; bean = 1'b1;
      tick();
      video_on = 1'b0; goose = 1'b0; bean = 1'b0;
   endtask

   // Full hold-off, then a clean press; leaves the design in RUN.
   task automatic restart();
      pulse_frame(60);
      btn = 2'b10;
      tick(3);
      btn = 2'b00;
      tick(3);
   endtask

   initial begin
      btn = 2'b11; btn4 = 2'b00;
      video_on = 1'b1; goose = 1'b1; bean = 1'b1;
      frame_tick = 1'b1; score_tick = 1'b1; score_tick4 = 1'b0;
      reset = 1'b0;

      // 1: reset with buttons and collision active
      tick(5);
      check("rst_state", state, 2'b00);
      check("rst_score", score, 0);
      check("rst_score_hi", score_hi, 0);
      check("rst_hit", hit, 0);
      check("rst_new_hi", new_hi, 0);
      video_on = 1'b0; goose = 1'b0; bean = 1'b0;
      frame_tick = 1'b0; score_tick = 1'b0;
      reset = 1'b1;
      tick(6);
      check("held_no_start", state, 2'b00);
      btn = 2'b00;
      tick(4);
      check("released_idle", state, 2'b00);

      // 2: start latency and scoring
      btn = 2'b01;
      tick(2);
      check("start_lat2", state, 2'b00);
      tick(1);
      check("start_lat3", state, 2'b01);
      btn = 2'b00;
      tick(2);
      pulse_score(7);
      check("score7", score, 7);
      check("run_hit", hit, 0);

      // 3: collision coinciding with a score tick
      score_tick = 1'b1;
      collide();
      score_tick = 1'b0;
      check("over_state", state, 2'b10);
      check("over_hit", hit, 1);
      check("over_score", score, 7);
      check("over_score_hi", score_hi, 7);
      check("over_new_hi", new_hi, 1);

      // 4: hold-off behaviour
      pulse_frame(59);
      btn = 2'b01;
      tick(5);
      check("early_press", state, 2'b10);
      pulse_frame(1);
      tick(5);
      check("held_across", state, 2'b10);
      check("score_held", score, 7);
      btn = 2'b00;
      tick(4);
      btn = 2'b01;
      tick(3);
      check("restart_state", state, 2'b01);
      check("restart_score", score, 0);
      check("restart_score_hi", score_hi, 7);
      check("restart_new_hi", new_hi, 0);
      check("restart_hit", hit, 0);
      btn = 2'b00;
      tick(2);

      // 5: lower score keeps the record, equal score does not beat it
      pulse_score(5);
      collide();
      check("run2_state", state, 2'b10);
      check("run2_score", score, 5);
      check("run2_score_hi", score_hi, 7);
      check("run2_new_hi", new_hi, 0);
      restart();
      check("run3_state", state, 2'b01);
      pulse_score(7);
      collide();
      check("eq_score_hi", score_hi, 7);
      check("eq_new_hi", new_hi, 0);
      restart();
      pulse_score(8);
      collide();
      check("beat_score_hi", score_hi, 8);
      check("beat_new_hi", new_hi, 1);

      // saturation on the narrow instance
      btn4 = 2'b01;
      tick(3);
      check("w4_state", state4, 2'b01);
      btn4 = 2'b00;
      for (int i = 0; i < 20; i++) begin
         score_tick4 = 1'b1;
         tick();
         score_tick4 = 1'b0;
      end
      check("w4_sat", score4, 15);

      // 6: asynchronous reset in OVER
      check("pre_rst_over", state, 2'b10);
      #1;
      reset = 1'b0;
      #1;
      check("async_state", state, 2'b00);
      check("async_score_hi", score_hi, 0);
      check("async_hit", hit, 0);
      check("async_w4_score", score4, 0);
      tick(2);
      reset = 1'b1;
      tick(2);
      check("post_rst_state", state, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
